aes128_iter_engine: RTL
=======================

# aes128_iter_engine

Iterative AES-128 encryption engine that sequences the existing round transforms (addRoundKey, subBytes128, shift128, mixCol128, expandKey) under its own state machine. No external step-select bus is needed. Blocks enter and leave through valid/ready handshakes. Parameter `FUSED` selects the schedule: one full round per cycle (throughput) or one transform per cycle (reuses a single narrow datapath step, shorter critical path). It sits between the send-side packetiser and the output framer in AES_send.

## Interface
- `FUSED`, default 0: 0 = one transform per cycle, 1 = whole round per cycle.
- `NR`, default 10: round count; only 10 is supported for AES-128, and other values are elaborated but out of scope.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_data`/`in_key` valid.
- `in_ready` out 1: engine can accept a block.
- `in_data` in 128: plaintext; byte 0 = `[127:120]` (FIPS-197 order).
- `in_key` in 128: cipher key, same byte order.
- `out_valid` out 1: `out_data` holds a finished ciphertext.
- `out_ready` in 1: consumer accepts `out_data`.
- `out_data` out 128: ciphertext.
- `busy` out 1: a block is in flight (not IDLE).
- `round` out 4: current round index, 0 in IDLE/DONE.

## Operation
- Registers: `st` (128, state array), `rk` (128, current round key), `round` (4), `step` (2, FUSED=0 only), FSM `fsm`.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `st` <= `in_data ^ in_key` (initial AddRoundKey), `rk` <= `in_key`, `round` <= 1, `step` <= SUB, go to RUN.
- RUN, FUSED=1: each cycle `st` <= AddRoundKey(Mix(Shift(Sub(st))), K), where:
  - K = expandKey(`rk`, `round`).
  - Mix is bypassed when `round`==NR.
  - `rk` <= K, and `round` increments.
  - After round NR, go to DONE.
- RUN, FUSED=0, steps per round:
  - SUB: `st` <= Sub(st).
  - SHI: `st` <= Shift(st), and `rk` <= expandKey(`rk`, `round`).
  - MIX: `st` <= Mix(st). This step is skipped when `round`==NR (SHI goes directly to ADD).
  - ADD: `st` <= st ^ `rk`. Then `round`++ and `step` <= SUB. If `round`==NR, go to DONE instead.
- expandKey `count` input is driven with `round` zero-extended to 8 bits (values 1..10 → rcon 01..36).
- DONE:
  - `out_valid`=1 and `out_data`=`st`, both held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- `in_ready`=1 only in IDLE. Back-to-back overlap is not supported.
- `out_data` is driven from `st` at all times. It is meaningful only while `out_valid`.
- Unused FSM/step encodings go to IDLE on the next edge; no X assignment.

## Timing
- Reset (sync, `rst`=1 at edge): `fsm`=IDLE, `st`=0, `rk`=0, `round`=0, `step`=SUB.
  - Resulting outputs: `out_valid`=0, `out_data`=0, `busy`=0, `in_ready`=1.
- `rst` has priority over every other event. Reset mid-RUN or in DONE discards the block; no `out_valid` follows it.
- `in_valid`/`out_ready` are sampled at the rising edge only. `in_data`/`in_key` are captured on the accept edge and may change afterwards.
- Latency, measured from the accept edge to the first edge where `out_valid`=1:
  - FUSED=1: NR = 10 cycles.
  - FUSED=0: 4·(NR−1)+3 = 39 cycles.
- Accepting edge N: `busy`=1 from N+1. `round` shows 1 during the first RUN cycle.
- DONE→IDLE on the `out_ready` edge: `in_ready`=1 in the following cycle, so the minimum block-to-block interval is latency+2 cycles.
- `in_valid` asserted while not IDLE is ignored; it is not queued.

## Test plan
- FIPS-197 App. B, both FUSED values:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Response: `out_data`=3925841d02dc09fbdc118597196a0b32, with `out_valid` exactly 10 (FUSED=1) or 39 (FUSED=0) cycles after accept.
- FIPS-197 App. C.1:
  - Stimulus: key 000102…0f, pt 00112233445566778899aabbccddeeff.
  - Response: 69c4e0d86a7b0430d8cdb78070b4c55a. Round-key trace after round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
- Output backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Response: `out_data` stable, `in_ready`=0, and a new `in_valid` is ignored. Release gives exactly one handshake, then `in_ready`=1 the next cycle.
- Mid-run reset:
  - Stimulus: assert `rst` at round 5.
  - Response: next cycle `busy`=0, `out_valid`=0, `round`=0, `out_data`=0. A following App. B block still gives the correct ciphertext.
- Back-to-back:
  - Stimulus: two blocks (App. B, then App. C.1) with `in_valid` held high and `out_ready`=1.
  - Response: both ciphertexts correct and in order, with the second accept edge exactly latency+2 cycles after the first.
- Idle robustness:
  - Stimulus: `in_valid` toggling with `rst` high.
  - Response: no accept, and `in_ready`=1 once `rst` drops.

Source files
------------

// File: rtl/aes128_iter_engine.sv
// Iterative AES-128 encryption engine with valid/ready block handshakes.
// FUSED=1 runs a whole round per cycle; FUSED=0 runs one round transform per cycle.
module aes128_iter_engine #(
    parameter int FUSED = 0,
    parameter int NR    = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round
);

    // state | meaning
    // IDLE  | waiting for a block, in_ready=1
    // RUN   | rounds in progress (step selects the transform when FUSED=0)
    // DONE  | ciphertext held in st until out_ready
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;
    typedef enum logic [1:0] {SUB = 2'd0, SHI = 2'd1, MIX = 2'd2, ADD = 2'd3} step_t;

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_t         fsm, fsm_nxt;
    step_t        step, step_nxt;
    logic [127:0] st, st_nxt, rk, rk_nxt;
    logic [3:0]   round_nxt;
    logic [127:0] sb_st, sr_st, mc_st, fz_sr, fz_st, key_nxt;
    logic         last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as x^254 in GF(2^8) followed by the affine map, rather than a table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [7:0] count);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 2; i <= 10; i++)
            if (i <= int'(count)) r = xtime(r);
        return r;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] count);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t ^ {rcon(count), 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign last    = (round == NR_L);
    assign key_nxt = expand_key(rk, {4'h0, round});
    assign sb_st   = sub_bytes(st);
    assign sr_st   = shift_rows(st);
    assign mc_st   = mix_cols(st);
    assign fz_sr   = shift_rows(sb_st);
    assign fz_st   = last ? fz_sr : mix_cols(fz_sr);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            step  <= SUB;
            st    <= '0;
            rk    <= '0;
            round <= '0;
        end else begin
            fsm   <= fsm_nxt;
            step  <= step_nxt;
            st    <= st_nxt;
            rk    <= rk_nxt;
            round <= round_nxt;
        end
    end

    always_comb begin
        fsm_nxt   = fsm;
        step_nxt  = step;
        st_nxt    = st;
        rk_nxt    = rk;
        round_nxt = round;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    st_nxt    = in_data ^ in_key;
                    rk_nxt    = in_key;
                    round_nxt = 4'd1;
                    step_nxt  = SUB;
                    fsm_nxt   = RUN;
                end
            end
            RUN: begin
                if (FUSED != 0) begin
                    st_nxt = fz_st ^ key_nxt;
                    rk_nxt = key_nxt;
                    if (last) begin
                        round_nxt = 4'd0;
                        fsm_nxt   = DONE;
                    end else begin
                        round_nxt = round + 4'd1;
                    end
                end else begin
                    case (step)
                        SUB: begin
                            st_nxt   = sb_st;
                            step_nxt = SHI;
                        end
                        SHI: begin
                            st_nxt   = sr_st;
                            rk_nxt   = key_nxt;
                            step_nxt = last ? ADD : MIX;
                        end
                        MIX: begin
                            st_nxt   = mc_st;
                            step_nxt = ADD;
                        end
                        ADD: begin
                            st_nxt   = st ^ rk;
                            step_nxt = SUB;
                            if (last) begin
                                round_nxt = 4'd0;
                                fsm_nxt   = DONE;
                            end else begin
                                round_nxt = round + 4'd1;
                            end
                        end
                        default: fsm_nxt = IDLE;
                    endcase
                end
            end
            DONE: begin
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign out_data  = st;

endmodule
